// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   state_t        : scanner FSM states
//   NUM_ROWS/COLS  : matrix geometry
//   CODE_W         : width of the emitted key code (row_idx*4 + col_idx)
//   onehot_to_idx  : index of the lowest set bit of a 4-bit vector
//                    (exact for one-hot column drive, priority for rows)
package keypad_scanner_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int IDX_W    = 2;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Walk from the top bit down so the lowest set bit is the one left in idx.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_ROWS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_stable_cnt.sv
// Saturating stability counter shared by press and release debouncing.
//   clck    : system clock, rising edge
//   reste   : asynchronous active-low reset
//   clr     : synchronous clear (wins over inc)
//   inc     : count one more stable sample
//   at_last : the next stable sample brings the count to TERM, so the
//             owner can act on the same edge that completes the count
module keypad_stable_cnt #(
    parameter int CNT_W = 8,
    parameter int TERM  = 4
) (
    input  logic clck,
    input  logic reste,
    input  logic clr,
    input  logic inc,
    output logic at_last
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERM - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clck or negedge reste) begin
        if (!reste) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_last = (count >= CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debouncing.
//   clck      : system clock, rising edge
//   reste     : asynchronous active-low reset
//   row       : row sense, active-high, bit r = row r
//   col       : one-hot column drive, bit c = column c
//   key_code  : last accepted key, row_idx*4 + col_idx (held until next press)
//   key_valid : one-cycle pulse when a debounced press is accepted
//   key_held  : high from acceptance until debounced release
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV        = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                clck,
    input  logic                reste,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [NUM_COLS-1:0] COL_FIRST  = NUM_COLS'(1);

    function automatic logic [NUM_COLS-1:0] rotl(input logic [NUM_COLS-1:0] v);
        return {v[NUM_COLS-2:0], v[NUM_COLS-1]};
    endfunction

    state_t              state, state_n;
    logic [NUM_COLS-1:0] col_n;
    logic [CNT_W-1:0]    dwell, dwell_n;
    logic [IDX_W-1:0]    row_idx, row_idx_n;
    logic [IDX_W-1:0]    col_idx, col_idx_n;
    logic [CODE_W-1:0]   code_n;
    logic                valid_n;
    logic                held_n;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                cnt_last;

    keypad_stable_cnt #(
        .CNT_W (CNT_W),
        .TERM  (DEBOUNCE_CYCLES)
    ) u_stable (
        .clck    (clck),
        .reste   (reste),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .at_last (cnt_last)
    );

    always_ff @(posedge clck or negedge reste) begin
        if (!reste) begin
            state     <= SCAN;
            col       <= COL_FIRST;
            dwell     <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            dwell     <= dwell_n;
            row_idx   <= row_idx_n;
            col_idx   <= col_idx_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = col;
        dwell_n   = dwell;
        row_idx_n = row_idx;
        col_idx_n = col_idx;
        code_n    = key_code;
        valid_n   = 1'b0;
        held_n    = key_held;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        case (state)
            SCAN: begin
                // Rows are only trusted on the last dwell clock, after the
                // column drive has had time to settle through the matrix.
                if (dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    if (row != '0) begin
                        row_idx_n = onehot_to_idx(row);
                        col_idx_n = onehot_to_idx(col);
                        cnt_clr   = 1'b1;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_n = rotl(col);
                    end
                end else begin
                    dwell_n = dwell + CNT_W'(1);
                end
            end

            DEBOUNCE: begin
                if (row[row_idx]) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        code_n  = {row_idx, col_idx};
                        valid_n = 1'b1;
                        held_n  = 1'b1;
                        state_n = HELD;
                    end
                end else begin
                    // Bounce: abandon this key and carry on from the next column.
                    cnt_clr = 1'b1;
                    col_n   = rotl(col);
                    dwell_n = '0;
                    state_n = SCAN;
                end
            end

            HELD: begin
                // Column stays frozen; only the accepted row is watched.
                if (!row[row_idx]) begin
                    cnt_clr = 1'b1;
                    state_n = RELEASE;
                end
            end

            RELEASE: begin
                // Any activity on the frozen column restarts the release wait.
                if (row == '0) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        held_n  = 1'b0;
                        col_n   = rotl(col);
                        dwell_n = '0;
                        state_n = SCAN;
                    end
                end else begin
                    cnt_clr = 1'b1;
                    state_n = HELD;
                end
            end

            default: begin
                state_n = SCAN;
            end
        endcase
    end

endmodule
